// File: rtl/wfid_rr_encoder_40_to_6.sv
// Round-robin 40-to-6 wavefront ID encoder with a registered valid/accept pick output.
// Define WFID_ENC_ONEHOT_OUT_EN to add the registered one-hot pick_onehot output.
module wfid_rr_encoder_40_to_6 #(
    parameter int NUM_SLOTS = 40,
    parameter int ID_WIDTH  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SLOTS-1:0] req,
    input  logic                 pick_accept,
    output logic                 pick_valid,
`ifdef WFID_ENC_ONEHOT_OUT_EN
    output logic [ID_WIDTH-1:0]  pick_wfid,
    output logic [NUM_SLOTS-1:0] pick_onehot
`else
    output logic [ID_WIDTH-1:0]  pick_wfid
`endif
);

    localparam logic [ID_WIDTH:0]   SLOTS_W   = (ID_WIDTH + 1)'(NUM_SLOTS);
    localparam logic [ID_WIDTH-1:0] LAST_SLOT = ID_WIDTH'(NUM_SLOTS - 1);

    logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
    logic                 valid_q, valid_d;
    logic [ID_WIDTH-1:0]  wfid_q, wfid_d;

    logic                 accept;
    logic                 withdraw;
    logic                 load;
    logic [ID_WIDTH-1:0]  start;
    logic [NUM_SLOTS-1:0] acceptMask;
    logic [NUM_SLOTS-1:0] searchReq;
    logic                 found;
    logic [ID_WIDTH-1:0]  foundIdx;
    logic [ID_WIDTH:0]    idxWide;

    function automatic logic [ID_WIDTH-1:0] wrapInc(input logic [ID_WIDTH-1:0] v);
        if (v == LAST_SLOT) begin
            return '0;
        end
        return v + ID_WIDTH'(1);
    endfunction

    assign accept     = valid_q & pick_accept;
    assign withdraw   = valid_q & ~pick_accept & ~req[wfid_q];
    assign load       = ~valid_q | pick_accept | withdraw;
    assign start      = accept ? wrapInc(wfid_q) : ptr_q;
    // The wfid being consumed this cycle must not be re-picked immediately.
    assign acceptMask = accept ? (NUM_SLOTS'(1) << wfid_q) : '0;
    assign searchReq  = req & ~acceptMask;

    always_comb begin
        found    = 1'b0;
        foundIdx = '0;
        idxWide  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idxWide = {1'b0, start} + (ID_WIDTH + 1)'(i);
            if (idxWide >= SLOTS_W) begin
                idxWide = idxWide - SLOTS_W;
            end
            if (!found && searchReq[idxWide[ID_WIDTH-1:0]]) begin
                found    = 1'b1;
                foundIdx = idxWide[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        wfid_d  = wfid_q;
        if (accept) begin
            ptr_d = wrapInc(wfid_q);
        end
        // With no requester the old wfid is kept; only valid drops.
        if (load) begin
            valid_d = found;
            if (found) begin
                wfid_d = foundIdx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            wfid_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            wfid_q  <= wfid_d;
        end
    end

    assign pick_valid = valid_q;
    assign pick_wfid  = wfid_q;

`ifdef WFID_ENC_ONEHOT_OUT_EN
    logic [NUM_SLOTS-1:0] onehot_q, onehot_d;

    always_comb begin
        onehot_d = onehot_q;
        if (load) begin
            onehot_d = found ? (NUM_SLOTS'(1) << foundIdx) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_q <= '0;
        end else begin
            onehot_q <= onehot_d;
        end
    end

    assign pick_onehot = onehot_q;
`endif

endmodule

// File: tb/tb_wfid_rr_encoder_40_to_6.sv
// Self-checking bench for wfid_rr_encoder_40_to_6: vector table plus a scoreboard queue.
// Also checks pick_onehot when WFID_ENC_ONEHOT_OUT_EN is defined.
module tb_wfid_rr_encoder_40_to_6;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] req;
    logic        pick_accept;
    logic        pick_valid;
    logic [5:0]  pick_wfid;
`ifdef WFID_ENC_ONEHOT_OUT_EN
    logic [39:0] pick_onehot;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [39:0] req;
        logic        acc;
        logic        expValid;
        logic [5:0]  expWfid;
        logic [5:0]  expPtr;
    } vec_t;

    typedef struct {
        logic       valid;
        logic [5:0] wfid;
        logic [5:0] ptr;
        int         tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    wfid_rr_encoder_40_to_6 dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .pick_accept (pick_accept),
        .pick_valid  (pick_valid),
`ifdef WFID_ENC_ONEHOT_OUT_EN
        .pick_wfid   (pick_wfid),
        .pick_onehot (pick_onehot)
`else
        .pick_wfid   (pick_wfid)
`endif
    );

    function automatic logic [39:0] bitOf(input int n);
        return 40'd1 << n;
    endfunction

    function automatic void addVec(input logic r, input logic [39:0] q, input logic a,
                                   input logic v, input int w, input int p);
        vec_t x;
        x.rst = r; x.req = q; x.acc = a;
        x.expValid = v; x.expWfid = 6'(w); x.expPtr = 6'(p);
        vecs.push_back(x);
    endfunction

    task automatic compare(input string name, input int tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (vector %0d): got %0h, expected %0h", name, tag, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: got no expected entry, expected one");
            return;
        end
        e = sb.pop_front();
        compare("pick_valid", e.tag, 64'(pick_valid), 64'(e.valid));
        compare("pick_wfid",  e.tag, 64'(pick_wfid),  64'(e.wfid));
        compare("ptr",        e.tag, 64'(dut.ptr_q),  64'(e.ptr));
`ifdef WFID_ENC_ONEHOT_OUT_EN
        compare("pick_onehot", e.tag, 64'(pick_onehot), e.valid ? 64'(bitOf(int'(e.wfid))) : 64'd0);
`endif
    endtask

    task automatic applyStimulus(input vec_t v, input int tag);
        exp_t e;
        @(negedge clk);
        rst         = v.rst;
        req         = v.req;
        pick_accept = v.acc;
        e.valid = v.expValid;
        e.wfid  = v.expWfid;
        e.ptr   = v.expPtr;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        vec_t v;
        rst         = 1'b1;
        req         = '0;
        pick_accept = 1'b0;

        // rst req acc -> valid wfid ptr
        addVec(1, 40'd0, 0, 0, 0, 0);
        addVec(0, bitOf(5), 0, 1, 5, 0);
        addVec(0, bitOf(5), 0, 1, 5, 0);
        addVec(0, bitOf(5), 1, 0, 5, 6);
        addVec(0, 40'd0, 0, 0, 5, 6);
        // Round robin over {3,10,39} with continuous accept
        addVec(1, 40'd0, 0, 0, 0, 0);
        addVec(0, bitOf(3) | bitOf(10) | bitOf(39), 1, 1, 3, 0);
        addVec(0, bitOf(3) | bitOf(10) | bitOf(39), 1, 1, 10, 4);
        addVec(0, bitOf(3) | bitOf(10) | bitOf(39), 1, 1, 39, 11);
        addVec(0, bitOf(3) | bitOf(10) | bitOf(39), 1, 1, 3, 0);
        addVec(0, bitOf(3) | bitOf(10) | bitOf(39), 1, 1, 10, 4);
        // Wrap at the 39 -> 0 boundary
        addVec(1, 40'd0, 0, 0, 0, 0);
        addVec(0, bitOf(38), 0, 1, 38, 0);
        addVec(0, bitOf(0) | bitOf(39), 1, 1, 39, 39);
        addVec(0, bitOf(0) | bitOf(39), 1, 1, 0, 0);
        addVec(0, bitOf(0) | bitOf(39), 1, 1, 39, 1);
        addVec(0, 40'd0, 0, 0, 39, 1);
        // Hold for five cycles, then withdraw twice
        addVec(1, 40'd0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) addVec(0, bitOf(7) | bitOf(8), 0, 1, 7, 0);
        addVec(0, bitOf(8), 0, 1, 8, 0);
        addVec(0, 40'd0, 0, 0, 8, 0);
        // Accept while idle is ignored; reset beats a same-cycle accept
        addVec(1, 40'd0, 0, 0, 0, 0);
        addVec(0, 40'd0, 1, 0, 0, 0);
        addVec(0, bitOf(20), 0, 1, 20, 0);
        addVec(1, bitOf(20), 1, 0, 0, 0);
        addVec(0, bitOf(1) | bitOf(20), 0, 1, 1, 0);
        addVec(0, bitOf(1) | bitOf(20), 1, 1, 20, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // All slots requesting with accept every cycle: 0..39 then wrap to 0
        v.rst = 1; v.req = '0; v.acc = 0; v.expValid = 0; v.expWfid = 0; v.expPtr = 0;
        applyStimulus(v, 1000);
        for (int i = 0; i < 42; i++) begin
            v.rst      = 0;
            v.req      = '1;
            v.acc      = 1;
            v.expValid = 1;
            v.expWfid  = 6'(i % 40);
            v.expPtr   = 6'(i % 40);
            applyStimulus(v, 1001 + i);
        end

`ifdef WFID_ENC_ONEHOT_OUT_EN
        v.rst = 1; v.req = '0; v.acc = 0; v.expValid = 0; v.expWfid = 0; v.expPtr = 0;
        applyStimulus(v, 2000);
        v.rst = 0; v.req = bitOf(12); v.expValid = 1; v.expWfid = 12;
        applyStimulus(v, 2001);
        compare("onehot_slot12", 2001, 64'(pick_onehot), 64'h00_0000_1000);
        v.req = '0; v.expValid = 0;
        applyStimulus(v, 2002);
        compare("onehot_cleared", 2002, 64'(pick_onehot), 64'd0);
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
